imm_alu_sequencer: RTL and testbench

- Hardwired control sequencer for immediate-type ALU instructions (addi, andi, ori) in the Mini SRC datapath.
- Replaces hand-driven T-state strobes: emits fetch (T0–T2) and execute (T3–T5) control signals cycle by cycle.
- Adds three things fixed sequencing lacks: parametrised memory wait states, opcode-selected ALU operation with illegal-opcode trap, and a continuous-run mode chaining instructions back to T0.
- Sits between the CPU top and the datapath control inputs.

---
 rtl/mini_src_ctrl_defs_pkg.sv | 38 +++
 rtl/imm_alu_sequencer.sv | 152 +++++++++++++++
 tb/tb_imm_alu_sequencer.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/mini_src_ctrl_defs_pkg.sv
// rtl/mini_src_ctrl_defs_pkg.sv - shared Mini SRC control-sequencer state codes, opcodes and ALU-select decode
package mini_src_ctrl_defs;

   localparam int STATE_W = 3;

   // Sequencer state encodings; every 3-bit code is assigned
   localparam logic [STATE_W-1:0] S_IDLE = 3'd0;
   localparam logic [STATE_W-1:0] S_T0   = 3'd1;
   localparam logic [STATE_W-1:0] S_T1   = 3'd2;
   localparam logic [STATE_W-1:0] S_T2   = 3'd3;
   localparam logic [STATE_W-1:0] S_T3   = 3'd4;
   localparam logic [STATE_W-1:0] S_T4   = 3'd5;
   localparam logic [STATE_W-1:0] S_T5   = 3'd6;
   localparam logic [STATE_W-1:0] S_ILL  = 3'd7;

   // Mini SRC opcode field (IR[31:27]) values shared by all sequencers
   localparam int            MINI_OPC_W   = 5;
   localparam logic [4:0]    MINI_OPC_ADDI = 5'b01100;
   localparam logic [4:0]    MINI_OPC_ANDI = 5'b01101;
   localparam logic [4:0]    MINI_OPC_ORI  = 5'b01110;

   // Maps an opcode onto the one-hot {ADD, AND, OR} ALU select; unknown codes give all zero
   function automatic logic [2:0] alu_sel(input logic [MINI_OPC_W-1:0] opc,
                                          input logic [MINI_OPC_W-1:0] opc_add,
                                          input logic [MINI_OPC_W-1:0] opc_and,
                                          input logic [MINI_OPC_W-1:0] opc_or);
      logic [2:0] sel;
      sel = 3'b000;
      if (opc == opc_add)
         sel = 3'b100;
      else if (opc == opc_and)
         sel = 3'b010;
      else if (opc == opc_or)
         sel = 3'b001;
      return sel;
   endfunction

endpackage

// File: rtl/imm_alu_sequencer.sv
// rtl/imm_alu_sequencer.sv - hardwired T0-T5 control sequencer for addi/andi/ori with wait states, trap and run mode
module imm_alu_sequencer
   import mini_src_ctrl_defs::*;
#(
   parameter int               OPC_W    = 5,
   parameter int               MEM_WAIT = 0,
   parameter logic [OPC_W-1:0] OPC_ADDI = MINI_OPC_ADDI,
   parameter logic [OPC_W-1:0] OPC_ANDI = MINI_OPC_ANDI,
   parameter logic [OPC_W-1:0] OPC_ORI  = MINI_OPC_ORI
)(
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             run,
   input  logic [OPC_W-1:0] ir_opcode,
   output logic             busy,
   output logic             done,
   output logic             illegal,
   output logic             PCout,
   output logic             IncPC,
   output logic             MARin,
   output logic             PCin,
   output logic             Read,
   output logic             MDRin,
   output logic             MDRout,
   output logic             IRin,
   output logic             Grb,
   output logic             Gra,
   output logic             Rout,
   output logic             Rin,
   output logic             Yin,
   output logic             Cout,
   output logic             Zin,
   output logic             Zlowout,
   output logic             ADD,
   output logic             AND,
   output logic             OR
);

   // Four bits hold the largest supported wait (15) without wrapping
   localparam logic [3:0] WAIT_MAX = 4'(MEM_WAIT);

   logic [STATE_W-1:0] state_q;
   logic [STATE_W-1:0] state_d;
   logic [3:0]         wait_q;
   logic [OPC_W-1:0]   opc_q;
   logic               opc_legal;
   logic [2:0]         alu_q;

   assign opc_legal = (ir_opcode == OPC_ADDI) || (ir_opcode == OPC_ANDI) ||
                      (ir_opcode == OPC_ORI);
   assign alu_q     = alu_sel(opc_q, OPC_ADDI, OPC_ANDI, OPC_ORI);

   // State register
   always_ff @(posedge clk) begin
      if (reset)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   // Memory wait counter (counts extra T1 cycles) and opcode latch captured while in T3
   always_ff @(posedge clk) begin
      if (reset) begin
         wait_q <= 4'd0;
         opc_q  <= '0;
      end else begin
         if (state_q == S_T1 && wait_q != WAIT_MAX)
            wait_q <= wait_q + 4'd1;
         else
            wait_q <= 4'd0;
         if (state_q == S_T3)
            opc_q <= ir_opcode;
      end
   end

   // Next-state decode
   always_comb begin
      state_d = S_IDLE;
      case (state_q)
         S_IDLE: state_d = start ? S_T0 : S_IDLE;
         S_T0:   state_d = S_T1;
         S_T1:   state_d = (wait_q == WAIT_MAX) ? S_T2 : S_T1;
         S_T2:   state_d = S_T3;
         S_T3:   state_d = opc_legal ? S_T4 : S_ILL;
         S_T4:   state_d = S_T5;
         S_T5:   state_d = run ? S_T0 : S_IDLE;
         S_ILL:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Moore strobe decode from the registered state; PCout stays reserved at 0
   always_comb begin
      busy    = (state_q != S_IDLE);
      done    = 1'b0;
      illegal = 1'b0;
      PCout   = 1'b0;
      IncPC   = 1'b0;
      MARin   = 1'b0;
      PCin    = 1'b0;
      Read    = 1'b0;
      MDRin   = 1'b0;
      MDRout  = 1'b0;
      IRin    = 1'b0;
      Grb     = 1'b0;
      Gra     = 1'b0;
      Rout    = 1'b0;
      Rin     = 1'b0;
      Yin     = 1'b0;
      Cout    = 1'b0;
      Zin     = 1'b0;
      Zlowout = 1'b0;
      ADD     = 1'b0;
      AND     = 1'b0;
      OR      = 1'b0;
      case (state_q)
         S_T0: begin
            IncPC = 1'b1;
            MARin = 1'b1;
            PCin  = 1'b1;
         end
         S_T1: begin
            Read  = 1'b1;
            MDRin = 1'b1;
         end
         S_T2: begin
            MDRout = 1'b1;
            IRin   = 1'b1;
         end
         S_T3: begin
            Grb  = 1'b1;
            Rout = 1'b1;
            Yin  = 1'b1;
         end
         S_T4: begin
            Cout = 1'b1;
            Zin  = 1'b1;
            {ADD, AND, OR} = alu_q;
         end
         S_T5: begin
            Zlowout = 1'b1;
            Gra     = 1'b1;
            Rin     = 1'b1;
            done    = 1'b1;
         end
         S_ILL: illegal = 1'b1;
         default: ;
      endcase
   end

endmodule

// File: tb/tb_imm_alu_sequencer.sv
// tb/tb_imm_alu_sequencer.sv - directed self-checking bench for imm_alu_sequencer
module tb_imm_alu_sequencer;

   // Output vector bit masks: {busy,done,illegal,PCout,IncPC,MARin,PCin,Read,MDRin,MDRout,IRin,
   //                           Grb,Gra,Rout,Rin,Yin,Cout,Zin,Zlowout,ADD,AND,OR}
   localparam logic [21:0] B_BUSY   = 22'b1 << 21;
   localparam logic [21:0] B_DONE   = 22'b1 << 20;
   localparam logic [21:0] B_ILL    = 22'b1 << 19;
   localparam logic [21:0] B_INCPC  = 22'b1 << 17;
   localparam logic [21:0] B_MARIN  = 22'b1 << 16;
   localparam logic [21:0] B_PCIN   = 22'b1 << 15;
   localparam logic [21:0] B_READ   = 22'b1 << 14;
   localparam logic [21:0] B_MDRIN  = 22'b1 << 13;
   localparam logic [21:0] B_MDROUT = 22'b1 << 12;
   localparam logic [21:0] B_IRIN   = 22'b1 << 11;
   localparam logic [21:0] B_GRB    = 22'b1 << 10;
   localparam logic [21:0] B_GRA    = 22'b1 << 9;
   localparam logic [21:0] B_ROUT   = 22'b1 << 8;
   localparam logic [21:0] B_RIN    = 22'b1 << 7;
   localparam logic [21:0] B_YIN    = 22'b1 << 6;
   localparam logic [21:0] B_COUT   = 22'b1 << 5;
   localparam logic [21:0] B_ZIN    = 22'b1 << 4;
   localparam logic [21:0] B_ZLOW   = 22'b1 << 3;
   localparam logic [21:0] B_ADD    = 22'b1 << 2;
   localparam logic [21:0] B_AND    = 22'b1 << 1;
   localparam logic [21:0] B_OR     = 22'b1;

   localparam logic [21:0] E_IDLE = 22'b0;
   localparam logic [21:0] E_T0   = B_BUSY | B_INCPC | B_MARIN | B_PCIN;
   localparam logic [21:0] E_T1   = B_BUSY | B_READ | B_MDRIN;
   localparam logic [21:0] E_T2   = B_BUSY | B_MDROUT | B_IRIN;
   localparam logic [21:0] E_T3   = B_BUSY | B_GRB | B_ROUT | B_YIN;
   localparam logic [21:0] E_T4   = B_BUSY | B_COUT | B_ZIN;
   localparam logic [21:0] E_T5   = B_BUSY | B_ZLOW | B_GRA | B_RIN | B_DONE;
   localparam logic [21:0] E_ILL  = B_BUSY | B_ILL;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start0 = 1'b0;
   logic       start3 = 1'b0;
   logic       run = 1'b0;
   logic [4:0] ir_opcode = 5'b00000;

   int n_chk  = 0;
   int n_pass = 0;

   logic busy0, done0, ill0, pcout0, incpc0, marin0, pcin0, read0, mdrin0, mdrout0, irin0;
   logic grb0, gra0, rout0, rin0, yin0, cout0, zin0, zlow0, add0, and0, or0;
   logic busy3, done3, ill3, pcout3, incpc3, marin3, pcin3, read3, mdrin3, mdrout3, irin3;
   logic grb3, gra3, rout3, rin3, yin3, cout3, zin3, zlow3, add3, and3, or3;
   logic [21:0] o0, o3;

   assign o0 = {busy0, done0, ill0, pcout0, incpc0, marin0, pcin0, read0, mdrin0, mdrout0, irin0,
                grb0, gra0, rout0, rin0, yin0, cout0, zin0, zlow0, add0, and0, or0};
   assign o3 = {busy3, done3, ill3, pcout3, incpc3, marin3, pcin3, read3, mdrin3, mdrout3, irin3,
                grb3, gra3, rout3, rin3, yin3, cout3, zin3, zlow3, add3, and3, or3};

   always #5 clk = ~clk;

   imm_alu_sequencer #(.MEM_WAIT(0)) dut0 (
      .clk(clk), .reset(reset), .start(start0), .run(run), .ir_opcode(ir_opcode),
      .busy(busy0), .done(done0), .illegal(ill0), .PCout(pcout0), .IncPC(incpc0),
      .MARin(marin0), .PCin(pcin0), .Read(read0), .MDRin(mdrin0), .MDRout(mdrout0),
      .IRin(irin0), .Grb(grb0), .Gra(gra0), .Rout(rout0), .Rin(rin0), .Yin(yin0),
      .Cout(cout0), .Zin(zin0), .Zlowout(zlow0), .ADD(add0), .AND(and0), .OR(or0)
   );

   imm_alu_sequencer #(.MEM_WAIT(3)) dut3 (
      .clk(clk), .reset(reset), .start(start3), .run(run), .ir_opcode(ir_opcode),
      .busy(busy3), .done(done3), .illegal(ill3), .PCout(pcout3), .IncPC(incpc3),
      .MARin(marin3), .PCin(pcin3), .Read(read3), .MDRin(mdrin3), .MDRout(mdrout3),
      .IRin(irin3), .Grb(grb3), .Gra(gra3), .Rout(rout3), .Rin(rin3), .Yin(yin3),
      .Cout(cout3), .Zin(zin3), .Zlowout(zlow3), .ADD(add3), .AND(and3), .OR(or3)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [21:0] obs, input logic [21:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%06h expected=%06h", tag, obs, exp);
   endtask

   function automatic logic [21:0] obs_of(input bit d3);
      return d3 ? o3 : o0;
   endfunction

   // Steps one instruction from the T0 edge through T5; start must already be raised
   task automatic do_instr(input bit d3, input int mw, input logic [21:0] alu, input string tag);
      tick();
      start0 = 1'b0;
      start3 = 1'b0;
      chk({tag, "_t0"}, obs_of(d3), E_T0);
      for (int i = 0; i <= mw; i++) begin
         tick();
         chk($sformatf("%s_t1_%0d", tag, i), obs_of(d3), E_T1);
      end
      tick();
      chk({tag, "_t2"}, obs_of(d3), E_T2);
      tick();
      chk({tag, "_t3"}, obs_of(d3), E_T3);
      tick();
      chk({tag, "_t4"}, obs_of(d3), E_T4 | alu);
      tick();
      chk({tag, "_t5"}, obs_of(d3), E_T5);
   endtask

   initial begin
      // Reset for two cycles
      reset = 1'b1;
      tick();
      tick();
      chk("reset_dut0", o0, E_IDLE);
      chk("reset_dut3", o3, E_IDLE);
      reset = 1'b0;
      tick();
      chk("idle_hold", o0, E_IDLE);

      // andi, MEM_WAIT=0; IR switches to ADDI during T4 and must not alter the op
      ir_opcode = 5'b01101;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      chk("andi_t0", o0, E_T0);
      chk("andi_other_idle", o3, E_IDLE);
      tick();
      chk("andi_t1", o0, E_T1);
      tick();
      chk("andi_t2", o0, E_T2);
      tick();
      chk("andi_t3", o0, E_T3);
      tick();
      ir_opcode = 5'b01100;
      #1;
      chk("andi_t4_stable", o0, E_T4 | B_AND);
      tick();
      chk("andi_t5_done", o0, E_T5);
      tick();
      chk("andi_idle", o0, E_IDLE);

      // addi, MEM_WAIT=3: four T1 cycles, done on the ninth edge
      ir_opcode = 5'b01100;
      start3 = 1'b1;
      do_instr(1'b1, 3, B_ADD, "addi_w3");
      tick();
      chk("addi_w3_idle", o3, E_IDLE);

      // Illegal opcode traps for one cycle and returns to IDLE even with run high
      ir_opcode = 5'b11111;
      run = 1'b1;
      start0 = 1'b1;
      tick();
      start0 = 1'b0;
      chk("ill_t0", o0, E_T0);
      tick();
      tick();
      tick();
      chk("ill_t3", o0, E_T3);
      tick();
      chk("ill_trap", o0, E_ILL);
      tick();
      chk("ill_idle", o0, E_IDLE);
      tick();
      chk("ill_stay_idle", o0, E_IDLE);

      // Run mode ori: three chained instructions, then drop run during the last T5
      ir_opcode = 5'b01110;
      run = 1'b1;
      start0 = 1'b1;
      do_instr(1'b0, 0, B_OR, "run1");
      do_instr(1'b0, 0, B_OR, "run2");
      do_instr(1'b0, 0, B_OR, "run3");
      run = 1'b0;
      tick();
      chk("run_end_idle", o0, E_IDLE);

      // Reset mid-instruction: dut0 in T4, dut3 deep in its T1 wait
      ir_opcode = 5'b01101;
      start0 = 1'b1;
      start3 = 1'b1;
      tick();
      start0 = 1'b0;
      start3 = 1'b0;
      tick();
      tick();
      tick();
      tick();
      chk("mid_t4", o0, E_T4 | B_AND);
      chk("mid_t1", o3, E_T1);
      reset = 1'b1;
      tick();
      chk("mid_reset_dut0", o0, E_IDLE);
      chk("mid_reset_dut3", o3, E_IDLE);
      reset = 1'b0;
      // A fresh instruction must see a full T1 wait, showing the counter restarted at 0
      ir_opcode = 5'b01100;
      start3 = 1'b1;
      do_instr(1'b1, 3, B_ADD, "post_reset");
      tick();
      chk("post_reset_idle", o3, E_IDLE);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
